// File: rtl/dcache_pkg.sv
// Shared types and line helpers for the direct-mapped write-back data cache.
// Combinational only; no latency or backpressure.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, RF} state_t;

  localparam int LINE_W    = 128;
  localparam int OFF_BITS  = 4;
  localparam int WORD_BITS = 2;

  function automatic logic [LINE_W-1:0] merge_bytes(
    input logic [LINE_W-1:0]    line,
    input logic [WORD_BITS-1:0] word,
    input logic [31:0]          wdata,
    input logic [3:0]           be
  );
    logic [LINE_W-1:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[int'(word)*32 + b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] get_word(
    input logic [LINE_W-1:0]    line,
    input logic [WORD_BITS-1:0] word
  );
    return line[int'(word)*32 +: 32];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, one synchronous write port.
// Write lands on the clock edge; no backpressure.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 7,
  parameter int IDX       = $clog2(NUM_LINES)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [IDX-1:0]    rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX-1:0]    wr_idx,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_valid,
  input  logic              wr_dirty
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    data_d [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
      dirty_d[wr_idx] = wr_dirty;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_line;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they skip reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller. Hit: resp at T+1; clean miss T+MEM_LAT+1;
// dirty miss T+2*MEM_LAT+1. cpu_req_ready is high only in IDLE, so requests stall during WB/RF.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int MEM_LAT   = 2,
  parameter int AWIDTH    = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [31:0]       cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  input  logic [3:0]        cpu_req_be,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_resp_rdata,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [AWIDTH-1:0] D_MEM_ADDR,
  output logic [LINE_W-1:0] D_MEM_DOUT,
  input  logic [LINE_W-1:0] D_MEM_DI,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = AWIDTH - IDX;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AWIDTH-1:0]     req_line_q, req_line_d;
  logic [WORD_BITS-1:0]  req_word_q, req_word_d;
  logic                  req_we_q, req_we_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic [3:0]            req_be_q, req_be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [AWIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]     mem_dout_q, mem_dout_d;
  logic [31:0]           hit_q, hit_d, miss_q, miss_d;

  logic [IDX-1:0]        cpu_idx, req_idx, rd_idx, wr_idx;
  logic [TAG_W-1:0]      cpu_tag, req_tag, rd_tag, wr_tag;
  logic [AWIDTH-1:0]     cpu_line;
  logic [WORD_BITS-1:0]  cpu_word;
  logic                  rd_valid, rd_dirty, hit, last;
  logic [LINE_W-1:0]     rd_line, hit_line, fill_line, wr_line;
  logic                  wr_en, wr_valid, wr_dirty;
  logic                  unused_addr_bits;

  assign cpu_word = cpu_req_addr[3:2];
  assign cpu_idx  = cpu_req_addr[IDX+3:4];
  assign cpu_tag  = cpu_req_addr[AWIDTH+3:IDX+4];
  assign cpu_line = cpu_req_addr[AWIDTH+3:4];
  assign req_idx  = req_line_q[IDX-1:0];
  assign req_tag  = req_line_q[AWIDTH-1:IDX];
  assign unused_addr_bits = ^{cpu_req_addr[31:AWIDTH+4], cpu_req_addr[1:0]};

  // Lookup uses the live request while idle, the latched one while the miss is in flight.
  assign rd_idx    = (state_q == IDLE) ? cpu_idx : req_idx;
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign last      = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign hit_line  = merge_bytes(rd_line, cpu_word, cpu_req_wdata, cpu_req_be);
  assign fill_line = req_we_q ? merge_bytes(D_MEM_DI, req_word_q, req_wdata_q, req_be_q)
                              : D_MEM_DI;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX       (IDX)
  ) u_array (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_line  (wr_line),
    .wr_tag   (wr_tag),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_line_d   = req_line_q;
    req_word_d   = req_word_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    req_be_d     = req_be_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    wr_en        = 1'b0;
    wr_idx       = req_idx;
    wr_line      = fill_line;
    wr_tag       = req_tag;
    wr_valid     = 1'b1;
    wr_dirty     = req_we_q;

    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_line_d  = cpu_line;
          req_word_d  = cpu_word;
          req_we_d    = cpu_req_we;
          req_wdata_d = cpu_req_wdata;
          req_be_d    = cpu_req_be;
          if (hit) begin
            hit_d        = hit_q + 32'd1;
            resp_valid_d = 1'b1;
            rdata_d      = get_word(cpu_req_we ? hit_line : rd_line, cpu_word);
            if (cpu_req_we) begin
              wr_en    = 1'b1;
              wr_idx   = cpu_idx;
              wr_line  = hit_line;
              wr_tag   = cpu_tag;
              wr_dirty = 1'b1;
            end
          end else begin
            miss_d = miss_q + 32'd1;
            cnt_d  = '0;
            if (rd_valid && rd_dirty) begin
              state_d    = WB;
              mem_addr_d = {rd_tag, cpu_idx};
              mem_dout_d = rd_line;
            end else begin
              state_d    = RF;
              mem_addr_d = cpu_line;
            end
          end
        end
      end
      WB: begin
        if (last) begin
          state_d    = RF;
          cnt_d      = '0;
          mem_addr_d = req_line_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RF: begin
        if (last) begin
          wr_en        = 1'b1;
          resp_valid_d = 1'b1;
          rdata_d      = get_word(fill_line, req_word_q);
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_line_q   <= '0;
      req_word_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_line_q   <= req_line_d;
      req_word_q   <= req_word_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      req_be_q     <= req_be_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_rdata = rdata_q;
  assign D_MEM_CSN      = !((state_q == WB) || (state_q == RF));
  assign D_MEM_WEN      = (state_q != WB);
  assign D_MEM_ADDR     = mem_addr_q;
  assign D_MEM_DOUT     = mem_dout_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-wide memory model answering during refill cycles.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic         CLK, RSTn;
  logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic [3:0]   cpu_req_be;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         D_MEM_CSN, D_MEM_WEN;
  logic [9:0]   D_MEM_ADDR;
  logic [127:0] D_MEM_DOUT, D_MEM_DI;
  logic [31:0]  hit_count, miss_count;

  logic [127:0] mem [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  logic         csn_l  [1:16];
  logic         wen_l  [1:16];
  logic [9:0]   addr_l [1:16];
  logic [127:0] dout_l [1:16];

  int          lat;
  logic [31:0] rdata;

  dcache_ctrl #(.NUM_LINES(8), .MEM_LAT(2), .AWIDTH(10)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_be     (cpu_req_be),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .D_MEM_CSN      (D_MEM_CSN),
    .D_MEM_WEN      (D_MEM_WEN),
    .D_MEM_ADDR     (D_MEM_ADDR),
    .D_MEM_DOUT     (D_MEM_DOUT),
    .D_MEM_DI       (D_MEM_DI),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Read data is only meaningful while a read is selected; otherwise drive a poison pattern.
  assign D_MEM_DI = (!D_MEM_CSN && D_MEM_WEN) ? mem[D_MEM_ADDR] : {4{32'hBAADF00D}};

  always @(posedge CLK) begin
    if (!D_MEM_CSN && !D_MEM_WEN) mem[D_MEM_ADDR] <= D_MEM_DOUT;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one request from a negedge, then log memory pins each cycle until the response.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output int l, output logic [31:0] rd);
    l  = 0;
    rd = '0;
    for (int k = 1; k <= 16; k++) begin
      csn_l[k]  = 1'b1;
      wen_l[k]  = 1'b1;
      addr_l[k] = '0;
      dout_l[k] = '0;
    end
    chk("ready_before_req", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    cpu_req_be    = be;
    @(posedge CLK);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        cpu_req_valid = 1'b0;
        cpu_req_we    = ~we;
        cpu_req_addr  = 32'hFFFF_FFFF;
        cpu_req_wdata = 32'h0BAD_0BAD;
        cpu_req_be    = 4'hF;
      end
      csn_l[k]  = D_MEM_CSN;
      wen_l[k]  = D_MEM_WEN;
      addr_l[k] = D_MEM_ADDR;
      dout_l[k] = D_MEM_DOUT;
      if (cpu_resp_valid) begin
        l  = k;
        rd = cpu_resp_rdata;
        break;
      end
    end
    if (l == 0) chk("resp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h004] = {32'h13, 32'h12, 32'h11, 32'h10};
    mem[10'h00C] = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    mem[10'h000] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    RSTn          = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    cpu_req_be    = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);

    chk("rst_ready", cpu_req_ready, 1'b1);
    chk("rst_resp_valid", cpu_resp_valid, 1'b0);
    chk("rst_rdata", cpu_resp_rdata, 32'h0);
    chk("rst_csn", D_MEM_CSN, 1'b1);
    chk("rst_wen", D_MEM_WEN, 1'b1);
    chk("rst_addr", D_MEM_ADDR, 10'h0);
    chk("rst_dout", D_MEM_DOUT, 128'h0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);

    // Clean miss on line 0x004.
    req(1'b0, 32'h40, 32'h0, 4'h0, lat, rdata);
    chk("ld40_lat", lat, 3);
    chk("ld40_rdata", rdata, 32'h10);
    for (int k = 1; k <= 2; k++) begin
      chk("ld40_rf_csn", csn_l[k], 1'b0);
      chk("ld40_rf_wen", wen_l[k], 1'b1);
      chk("ld40_rf_addr", addr_l[k], 10'h004);
    end
    chk("ld40_csn_idle", csn_l[3], 1'b1);
    chk("ld40_misses", miss_count, 32'd1);
    chk("ld40_hits", hit_count, 32'd0);

    // Load hit in the same line.
    req(1'b0, 32'h44, 32'h0, 4'h0, lat, rdata);
    chk("ld44_lat", lat, 1);
    chk("ld44_rdata", rdata, 32'h11);
    chk("ld44_csn", csn_l[1], 1'b1);
    chk("ld44_hits", hit_count, 32'd1);

    // Partial store hit, then read back.
    req(1'b1, 32'h48, 32'hDEADBEEF, 4'b0011, lat, rdata);
    chk("st48_lat", lat, 1);
    chk("st48_rdata", rdata, 32'h0000BEEF);
    chk("st48_csn", csn_l[1], 1'b1);
    req(1'b0, 32'h48, 32'h0, 4'h0, lat, rdata);
    chk("ld48_lat", lat, 1);
    chk("ld48_rdata", rdata, 32'h0000BEEF);
    chk("ld48_hits", hit_count, 32'd3);

    // Conflict miss on index 4 evicts the dirty line.
    req(1'b0, 32'hC0, 32'h0, 4'h0, lat, rdata);
    chk("ldC0_lat", lat, 5);
    chk("ldC0_rdata", rdata, 32'hC0);
    for (int k = 1; k <= 2; k++) begin
      chk("ldC0_wb_csn", csn_l[k], 1'b0);
      chk("ldC0_wb_wen", wen_l[k], 1'b0);
      chk("ldC0_wb_addr", addr_l[k], 10'h004);
    end
    chk("ldC0_wb_dout", dout_l[1], {32'h13, 32'h0000BEEF, 32'h11, 32'h10});
    for (int k = 3; k <= 4; k++) begin
      chk("ldC0_rf_csn", csn_l[k], 1'b0);
      chk("ldC0_rf_wen", wen_l[k], 1'b1);
      chk("ldC0_rf_addr", addr_l[k], 10'h00C);
    end
    chk("ldC0_mem_written", mem[10'h004], {32'h13, 32'h0000BEEF, 32'h11, 32'h10});
    chk("ldC0_misses", miss_count, 32'd2);

    // Store miss allocates line 0x010 (index 0, empty) dirty.
    req(1'b1, 32'h104, 32'h55, 4'b1111, lat, rdata);
    chk("st104_lat", lat, 3);
    chk("st104_rdata", rdata, 32'h55);
    chk("st104_rf_addr", addr_l[1], 10'h010);
    chk("st104_misses", miss_count, 32'd3);

    // Evict it with a load of line 0x000.
    req(1'b0, 32'h004, 32'h0, 4'h0, lat, rdata);
    chk("ld004_lat", lat, 5);
    chk("ld004_wb_wen", wen_l[1], 1'b0);
    chk("ld004_wb_addr", addr_l[1], 10'h010);
    chk("ld004_wb_word1", dout_l[2][63:32], 32'h55);
    chk("ld004_rdata", rdata, 32'hA1);
    chk("ld004_misses", miss_count, 32'd4);

    // Reset during the second refill cycle of a clean miss on line 0x008.
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h80;
    @(posedge CLK);
    @(negedge CLK);
    cpu_req_valid = 1'b0;
    chk("rstrf_csn1", D_MEM_CSN, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rstrf_csn2", D_MEM_CSN, 1'b0);
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    chk("rstrf_csn_after", D_MEM_CSN, 1'b1);
    chk("rstrf_ready_after", cpu_req_ready, 1'b1);
    chk("rstrf_no_resp", cpu_resp_valid, 1'b0);
    chk("rstrf_misses", miss_count, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    req(1'b0, 32'h44, 32'h0, 4'h0, lat, rdata);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rdata, 32'h11);
    chk("post_rst_misses", miss_count, 32'd1);
    chk("post_rst_hits", hit_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
